ahb_interconnect_n: RTL and testbench

Parametrised single-master AHB-Lite interconnect. It replaces the fixed decoder/mux pair in the SoC top. It decodes HADDR into NUM_SLAVES one-hot selects and registers the data-phase slave index. It multiplexes HRDATA, HREADY and HRESP back to the master. It includes a built-in default slave that issues AHB two-cycle ERROR responses. An optional watchdog terminates transfers to hung slaves.

---
 rtl/ahb_interconnect_n.sv | 180 ++++++++++++++++++
 tb/tb_ahb_interconnect_n.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_interconnect_n.sv
// Single-master AHB-Lite address decoder and response mux with a built-in ERROR default slave.
// Define TIMEOUT_EN to add a watchdog that aborts transfers to hung slaves.
module ahb_interconnect_n #(
  parameter int unsigned NUM_SLAVES     = 6,
  parameter int unsigned SLOT_SHIFT     = 24,
  parameter logic [31:0] NOMAP_RDATA    = 32'hDEADBEEF,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic [31:0]                HADDR,
  input  logic [1:0]                 HTRANS,
  output logic [NUM_SLAVES-1:0]      HSEL_S,
  input  logic [32*NUM_SLAVES-1:0]   HRDATA_S,
  input  logic [NUM_SLAVES-1:0]      HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]      HRESP_S,
  output logic [31:0]                HRDATA,
  output logic                       HREADY,
  output logic                       HRESP,
  output logic                       TIMEOUT_FLAG,
  output logic [3:0]                 TIMEOUT_SLV,
  input  logic                       TIMEOUT_CLR
);

  localparam int unsigned RW = 32 - SLOT_SHIFT;

  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;

  logic [RW-1:0] region;
  logic          addr_mapped;
  logic [3:0]    addr_idx;
  logic          accept_nomap;

  logic          dp_mapped;
  logic [3:0]    dp_idx;
  logic          dp_active;

  ds_state_t     ds_state;
  ds_state_t     ds_next;

  logic [31:0]   s_rdata;
  logic          s_ready;
  logic          s_resp;

  // Address decode: region field picks the slave, anything past NUM_SLAVES is unmapped
  assign region       = HADDR[31:SLOT_SHIFT];
  assign addr_mapped  = (32'(region) < NUM_SLAVES);
  assign addr_idx     = 4'(region);
  assign accept_nomap = HREADY && HTRANS[1] && !addr_mapped;

  always_comb begin
    HSEL_S = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      HSEL_S[i] = addr_mapped && (addr_idx == 4'(i));
    end
  end

  // Data-phase owner advances only when the current data phase completes
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_mapped <= 1'b0;
      dp_idx    <= '0;
      dp_active <= 1'b0;
    end else if (HREADY) begin
      dp_mapped <= addr_mapped;
      dp_idx    <= addr_idx;
      dp_active <= HTRANS[1];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) ds_state <= DS_IDLE;
    else          ds_state <= ds_next;
  end

  // Response decode lives in the output mux; this block only advances state
  always_comb begin
    ds_next = ds_state;
    case (ds_state)
      DS_IDLE: if (accept_nomap) ds_next = DS_ERR1;
      DS_ERR1: ds_next = DS_ERR2;
      DS_ERR2: ds_next = accept_nomap ? DS_ERR1 : DS_IDLE;
      default: ds_next = DS_IDLE;
    endcase
  end

  always_comb begin
    s_rdata = '0;
    s_ready = 1'b1;
    s_resp  = 1'b0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (dp_idx == 4'(i)) begin
        s_rdata = HRDATA_S[32*i +: 32];
        s_ready = HREADYOUT_S[i];
        s_resp  = HRESP_S[i];
      end
    end
  end

`ifdef TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {TO_IDLE, TO_ERR1, TO_ERR2} to_state_t;

  to_state_t     to_state;
  to_state_t     to_next;
  logic [CW-1:0] to_cnt;
  logic          stall;
  logic          to_fire;

  assign stall   = dp_active && dp_mapped && !HREADY;
  assign to_fire = (to_state == TO_IDLE) && stall && (to_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) to_state <= TO_IDLE;
    else          to_state <= to_next;
  end

  always_comb begin
    to_next = to_state;
    case (to_state)
      TO_IDLE: if (to_fire) to_next = TO_ERR1;
      TO_ERR1: to_next = TO_ERR2;
      TO_ERR2: to_next = TO_IDLE;
      default: to_next = TO_IDLE;
    endcase
  end

  // Wait-state counter is frozen while the abort pair is being issued
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      to_cnt       <= '0;
      TIMEOUT_FLAG <= 1'b0;
      TIMEOUT_SLV  <= '0;
    end else begin
      if (HREADY)                              to_cnt <= '0;
      else if ((to_state == TO_IDLE) && stall) to_cnt <= to_cnt + CW'(1);
      if (to_fire) begin
        TIMEOUT_FLAG <= 1'b1;
        TIMEOUT_SLV  <= dp_idx;
      end else if (TIMEOUT_CLR) begin
        TIMEOUT_FLAG <= 1'b0;
      end
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg   = TIMEOUT_CLR ^ dp_active ^ (TIMEOUT_CYCLES != 0);
  assign TIMEOUT_FLAG = 1'b0;
  assign TIMEOUT_SLV  = 4'd0;
`endif

  logic unused_bits;
  assign unused_bits = ^{HADDR[SLOT_SHIFT-1:0], HTRANS[0]};

  // Master-side response: selected slave, else default slave; watchdog overrides both
  always_comb begin
    HRDATA = NOMAP_RDATA;
    HREADY = 1'b1;
    HRESP  = 1'b0;
    if (dp_mapped) begin
      HRDATA = s_rdata;
      HREADY = s_ready;
      HRESP  = s_resp;
    end else begin
      HREADY = (ds_state != DS_ERR1);
      HRESP  = (ds_state != DS_IDLE);
    end
`ifdef TIMEOUT_EN
    if (to_state == TO_ERR1) begin
      HREADY = 1'b0;
      HRESP  = 1'b1;
    end else if (to_state == TO_ERR2) begin
      HREADY = 1'b1;
      HRESP  = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_ahb_interconnect_n.sv
// Bench for ahb_interconnect_n: directed vector table, randomized run against a
// transaction-level model, and hand sequences for watchdog abort and mid-transfer reset.
module tb_ahb_interconnect_n;

  localparam int NS = 6;
  localparam int TC = 8;
  localparam logic [31:0] NOM = 32'hDEADBEEF;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       haddr;
  logic [1:0]        htrans;
  logic [NS-1:0]     hsel;
  logic [32*NS-1:0]  srdata;
  logic [NS-1:0]     srdy;
  logic [NS-1:0]     srsp;
  logic [31:0]       hrdata;
  logic              hready;
  logic              hresp;
  logic              tflag;
  logic [3:0]        tslv;
  logic              tclr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ahb_interconnect_n #(
    .NUM_SLAVES(NS), .SLOT_SHIFT(24), .NOMAP_RDATA(NOM), .TIMEOUT_CYCLES(TC)
  ) dut (
    .HCLK(clk), .HRESETn(rst_n), .HADDR(haddr), .HTRANS(htrans), .HSEL_S(hsel),
    .HRDATA_S(srdata), .HREADYOUT_S(srdy), .HRESP_S(srsp), .HRDATA(hrdata),
    .HREADY(hready), .HRESP(hresp), .TIMEOUT_FLAG(tflag), .TIMEOUT_SLV(tslv),
    .TIMEOUT_CLR(tclr)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [5:0]  rdy;
    logic [5:0]  rsp;
    logic [5:0]  e_sel;
    logic        e_rdy;
    logic        e_rsp;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tv[$];

  // Reference model: data-phase owner (-1 = unmapped), error-beat countdown, wait count
  int m_sel, m_err, m_wait, m_to, m_slv;
  bit m_act, m_flag;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] dflt_rd(input int i);
    return (i == 2) ? 32'h12345678 : 32'hC0DE0000 + 32'(i);
  endfunction

  task automatic add(input logic [31:0] a, input logic [1:0] t, input logic [5:0] r,
                     input logic [5:0] p, input logic [5:0] es, input logic er,
                     input logic ep, input logic [31:0] ed);
    vec_t v;
    v.addr = a; v.trans = t; v.rdy = r; v.rsp = p;
    v.e_sel = es; v.e_rdy = er; v.e_rsp = ep; v.e_rd = ed;
    tv.push_back(v);
  endtask

  task automatic cyc(input logic [31:0] a, input logic [1:0] t, input logic [5:0] r,
                     input logic [5:0] p, input logic c);
    @(negedge clk);
    haddr = a; htrans = t; srdy = r; srsp = p; tclr = c;
    #1;
  endtask

  task automatic model_reset();
    m_sel = -1; m_err = 0; m_wait = 0; m_to = 0; m_slv = 0;
    m_act = 1'b0; m_flag = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; haddr = 32'hFF000000; htrans = 2'd0; srdy = '1; srsp = '0; tclr = 1'b0;
    for (int i = 0; i < NS; i++) srdata[32*i +: 32] = dflt_rd(i);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic model_expect(output logic [5:0] es, output logic er, output logic ep,
                              output logic [31:0] ed);
    int rg;
    rg = int'(haddr >> 24);
    es = (rg < NS) ? 6'(1 << rg) : 6'd0;
    ed = NOM; er = 1'b1; ep = 1'b0;
    if (m_sel >= 0) begin
      ed = srdata[32*m_sel +: 32];
      er = srdy[m_sel];
      ep = srsp[m_sel];
    end else begin
      er = (m_err != 1);
      ep = (m_err != 0);
    end
`ifdef TIMEOUT_EN
    if (m_to == 1) begin er = 1'b0; ep = 1'b1; end
    else if (m_to == 2) begin er = 1'b1; ep = 1'b1; end
`endif
  endtask

  task automatic model_step(input logic r);
    int rg;
    rg = int'(haddr >> 24);
`ifdef TIMEOUT_EN
    begin : to_model
      bit fire;
      int nto;
      fire = 1'b0; nto = 0;
      if (m_to == 1) nto = 2;
      else if (m_to == 2) nto = 0;
      else if (!r && m_act && m_sel >= 0) begin
        m_wait++;
        if (m_wait == TC) begin nto = 1; fire = 1'b1; m_slv = m_sel; end
      end
      if (r) m_wait = 0;
      if (fire) m_flag = 1'b1;
      else if (tclr) m_flag = 1'b0;
      m_to = nto;
    end
`endif
    if (m_err == 1) m_err = 2;
    else if (r && htrans[1] && rg >= NS) m_err = 1;
    else m_err = 0;
    if (r) begin
      m_sel = (rg < NS) ? rg : -1;
      m_act = htrans[1];
    end
  endtask

  initial begin
    logic [5:0]  es;
    logic        er, ep;
    logic [31:0] ed, a;
    int          rg;
    logic [5:0]  r, p;

    // Directed rows: inputs for one cycle and the response expected in that same cycle
    add(32'h02000010, 2'd2, 6'h3F, 6'h00, 6'h04, 1'b1, 1'b0, NOM);
    add(32'h00000000, 2'd0, 6'h3B, 6'h00, 6'h01, 1'b0, 1'b0, 32'h12345678);
    add(32'h00000000, 2'd0, 6'h3B, 6'h00, 6'h01, 1'b0, 1'b0, 32'h12345678);
    add(32'h00000000, 2'd0, 6'h3B, 6'h00, 6'h01, 1'b0, 1'b0, 32'h12345678);
    add(32'h0F000000, 2'd2, 6'h3F, 6'h00, 6'h00, 1'b1, 1'b0, 32'h12345678);
    add(32'h0F000000, 2'd0, 6'h3F, 6'h00, 6'h00, 1'b0, 1'b1, NOM);
    add(32'h0F000000, 2'd0, 6'h3F, 6'h00, 6'h00, 1'b1, 1'b1, NOM);
    add(32'h00000000, 2'd2, 6'h3F, 6'h00, 6'h01, 1'b1, 1'b0, NOM);
    add(32'h05000000, 2'd2, 6'h3E, 6'h00, 6'h20, 1'b0, 1'b0, 32'hC0DE0000);
    add(32'h05000000, 2'd2, 6'h3E, 6'h00, 6'h20, 1'b0, 1'b0, 32'hC0DE0000);
    add(32'h05000000, 2'd2, 6'h3F, 6'h00, 6'h20, 1'b1, 1'b0, 32'hC0DE0000);
    add(32'h0F000000, 2'd2, 6'h3F, 6'h00, 6'h00, 1'b1, 1'b0, 32'hC0DE0005);
    add(32'h03000000, 2'd2, 6'h3F, 6'h00, 6'h08, 1'b0, 1'b1, NOM);
    add(32'h03000000, 2'd2, 6'h3F, 6'h00, 6'h08, 1'b1, 1'b1, NOM);
    add(32'h00000000, 2'd0, 6'h37, 6'h08, 6'h01, 1'b0, 1'b1, 32'hC0DE0003);
    add(32'h00000000, 2'd0, 6'h3F, 6'h08, 6'h01, 1'b1, 1'b1, 32'hC0DE0003);
    add(32'h0F000000, 2'd0, 6'h3F, 6'h00, 6'h00, 1'b1, 1'b0, 32'hC0DE0000);
    add(32'h0F000000, 2'd0, 6'h3F, 6'h00, 6'h00, 1'b1, 1'b0, NOM);
    add(32'h05FFFFFF, 2'd0, 6'h3F, 6'h00, 6'h20, 1'b1, 1'b0, NOM);
    add(32'h06000000, 2'd2, 6'h3F, 6'h00, 6'h00, 1'b1, 1'b0, 32'hC0DE0005);
    add(32'h06000000, 2'd3, 6'h3F, 6'h00, 6'h00, 1'b0, 1'b1, NOM);
    add(32'h06000000, 2'd3, 6'h3F, 6'h00, 6'h00, 1'b1, 1'b1, NOM);
    add(32'h00000000, 2'd0, 6'h3F, 6'h00, 6'h01, 1'b0, 1'b1, NOM);
    add(32'h00000000, 2'd0, 6'h3F, 6'h00, 6'h01, 1'b1, 1'b1, NOM);
    add(32'h00000000, 2'd0, 6'h01, 6'h00, 6'h01, 1'b1, 1'b0, 32'hC0DE0000);
    add(32'hFF000000, 2'd1, 6'h3F, 6'h00, 6'h00, 1'b1, 1'b0, 32'hC0DE0000);
    add(32'h00000000, 2'd0, 6'h3F, 6'h00, 6'h01, 1'b1, 1'b0, NOM);

    do_reset();
    #1;
    chk("reset hready", 32'(hready), 32'd1);
    chk("reset hresp", 32'(hresp), 32'd0);
    chk("reset hrdata", hrdata, NOM);
    chk("reset tflag", 32'(tflag), 32'd0);
    chk("reset tslv", 32'(tslv), 32'd0);

    foreach (tv[i]) begin
      cyc(tv[i].addr, tv[i].trans, tv[i].rdy, tv[i].rsp, 1'b0);
      chk($sformatf("row%0d hsel", i), 32'(hsel), 32'(tv[i].e_sel));
      chk($sformatf("row%0d hready", i), 32'(hready), 32'(tv[i].e_rdy));
      chk($sformatf("row%0d hresp", i), 32'(hresp), 32'(tv[i].e_rsp));
      chk($sformatf("row%0d hrdata", i), hrdata, tv[i].e_rd);
      chk($sformatf("row%0d tflag", i), 32'(tflag), 32'd0);
    end

    // Randomized traffic with periodic all-slaves-stalled windows
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rg = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 255)) : int'($urandom_range(0, 7));
      a = {8'(rg), 24'($urandom)};
      for (int s = 0; s < NS; s++) begin
        r[s] = ((n % 60) >= 45) ? 1'b0 : ($urandom_range(0, 3) != 0);
        p[s] = ($urandom_range(0, 9) == 0);
        srdata[32*s +: 32] = $urandom;
      end
      cyc(a, 2'($urandom), r, p, ($urandom_range(0, 19) == 0));
      model_expect(es, er, ep, ed);
      chk($sformatf("rand%0d hsel", n), 32'(hsel), 32'(es));
      chk($sformatf("rand%0d hready", n), 32'(hready), 32'(er));
      chk($sformatf("rand%0d hresp", n), 32'(hresp), 32'(ep));
      chk($sformatf("rand%0d hrdata", n), hrdata, ed);
      chk($sformatf("rand%0d tflag", n), 32'(tflag), 32'(m_flag));
      chk($sformatf("rand%0d tslv", n), 32'(tslv), 32'(m_slv));
      model_step(er);
    end

    // Hung slave 1
    do_reset();
    cyc(32'h01000010, 2'd2, 6'h3F, 6'h00, 1'b0);
    chk("hung addr hsel", 32'(hsel), 32'h02);
    chk("hung addr hready", 32'(hready), 32'd1);
`ifdef TIMEOUT_EN
    for (int k = 0; k < TC; k++) begin
      cyc(32'h0, 2'd0, 6'h3D, 6'h00, 1'b0);
      chk($sformatf("to wait%0d hready", k), 32'(hready), 32'd0);
      chk($sformatf("to wait%0d hresp", k), 32'(hresp), 32'd0);
      chk($sformatf("to wait%0d tflag", k), 32'(tflag), 32'd0);
    end
    cyc(32'h0, 2'd0, 6'h3D, 6'h00, 1'b0);
    chk("to err1 hready", 32'(hready), 32'd0);
    chk("to err1 hresp", 32'(hresp), 32'd1);
    chk("to err1 tflag", 32'(tflag), 32'd1);
    chk("to err1 tslv", 32'(tslv), 32'd1);
    cyc(32'h0, 2'd0, 6'h3D, 6'h00, 1'b0);
    chk("to err2 hready", 32'(hready), 32'd1);
    chk("to err2 hresp", 32'(hresp), 32'd1);
    cyc(32'h0, 2'd0, 6'h3F, 6'h00, 1'b1);
    chk("to clr cycle tflag", 32'(tflag), 32'd1);
    chk("to after abort hresp", 32'(hresp), 32'd0);
    cyc(32'h0, 2'd0, 6'h3F, 6'h00, 1'b0);
    chk("to cleared tflag", 32'(tflag), 32'd0);
    cyc(32'h01000000, 2'd2, 6'h3F, 6'h00, 1'b1);
    for (int k = 0; k < TC; k++) cyc(32'h0, 2'd0, 6'h3D, 6'h00, 1'b1);
    cyc(32'h0, 2'd0, 6'h3D, 6'h00, 1'b1);
    chk("to set beats clr tflag", 32'(tflag), 32'd1);
    chk("to set beats clr hresp", 32'(hresp), 32'd1);
    cyc(32'h0, 2'd0, 6'h3D, 6'h00, 1'b0);
    chk("to second err2 hready", 32'(hready), 32'd1);
`else
    for (int k = 0; k < 12; k++) begin
      cyc(32'h0, 2'd0, 6'h3D, 6'h00, (k == 5));
      chk($sformatf("hung wait%0d hready", k), 32'(hready), 32'd0);
      chk($sformatf("hung wait%0d hresp", k), 32'(hresp), 32'd0);
      chk($sformatf("hung wait%0d tflag", k), 32'(tflag), 32'd0);
      chk($sformatf("hung wait%0d tslv", k), 32'(tslv), 32'd0);
    end
`endif
    // Reset pulled mid wait phase
    cyc(32'h01000000, 2'd2, 6'h3F, 6'h00, 1'b0);
    for (int k = 0; k < 3; k++) cyc(32'h0, 2'd0, 6'h3D, 6'h00, 1'b0);
    chk("pre-reset hready", 32'(hready), 32'd0);
    #1;
    rst_n = 1'b0; haddr = 32'hFF000000; htrans = 2'd0; srdy = '1;
    #1;
    chk("midreset hready", 32'(hready), 32'd1);
    chk("midreset hresp", 32'(hresp), 32'd0);
    chk("midreset tflag", 32'(tflag), 32'd0);
    chk("midreset hrdata", hrdata, NOM);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(32'h04000000, 2'd2, 6'h3F, 6'h00, 1'b0);
    chk("post-reset hsel", 32'(hsel), 32'h10);
    chk("post-reset addr hready", 32'(hready), 32'd1);
    cyc(32'h0, 2'd0, 6'h2F, 6'h00, 1'b0);
    chk("post-reset wait hready", 32'(hready), 32'd0);
    cyc(32'h0, 2'd0, 6'h3F, 6'h00, 1'b0);
    chk("post-reset done hready", 32'(hready), 32'd1);
    chk("post-reset done hresp", 32'(hresp), 32'd0);
    chk("post-reset done hrdata", hrdata, 32'hC0DE0004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
